// File: rtl/clk_ena_prescaler.sv
// clk_ena_prescaler
// Power-of-two clock prescaler feeding the 8-bit timer counter. Emits a
// registered, single-cycle clock-enable pulse on each rising edge of the
// selected prescaler tap. Supports a pause (presc_en) and a synchronous
// restart, triggered by sync_clr or by any change of the divide select.
module clk_ena_prescaler #(
  parameter int DIV_W = 4,  // prescaler width; tap k divides by 2^(k+1)
  parameter int CKS_W = 2   // divide-select width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             presc_en,
  input  logic [CKS_W-1:0] cks,
  input  logic             sync_clr,
  output logic             clk_ena,
  output logic [DIV_W-1:0] presc_cnt
);

  logic [DIV_W-1:0] r_div_cnt;
  logic [CKS_W-1:0] r_cks_q;
  logic             r_tap_d1;
  logic             r_clk_ena;

  logic             w_tap;
  logic             w_restart;

  // Tap mux: pick div_cnt bit selected by the registered select, clamping
  // out-of-range selects to the top bit.
  always_comb begin
    // NOTE: assign a default before any conditional write so no latch is inferred.
    w_tap = 1'b0;
    for (int k = 0; k < DIV_W; k++) begin
      if ((32'(r_cks_q) == k) ||
          ((k == DIV_W - 1) && (32'(r_cks_q) >= DIV_W))) begin
        w_tap = r_div_cnt[k];
      end
    end
  end

  // A restart is taken regardless of presc_en, so a new select or a clear
  // always lands cleanly even while the prescaler is paused.
  assign w_restart = sync_clr | (cks != r_cks_q);

  // Prescaler state: restart, count-and-detect, or freeze while paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      r_div_cnt <= '0;
      r_cks_q   <= '0;
      r_tap_d1  <= 1'b0;
      r_clk_ena <= 1'b0;
    end else if (w_restart) begin
      // Capturing the new select here makes a clear plus a select change a
      // single restart rather than two back-to-back ones.
      r_cks_q   <= cks;
      r_div_cnt <= '0;
      r_tap_d1  <= 1'b0;
      r_clk_ena <= 1'b0;
    end else if (presc_en) begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
      r_tap_d1  <= w_tap;
      // Rising edge only: the tap falling at wrap produces nothing.
      r_clk_ena <= w_tap & ~r_tap_d1;
    end else begin
      // Counter and tap history hold, so a tap rise seen just before the
      // pause is converted to exactly one pulse on resume.
      r_clk_ena <= 1'b0;
    end
  end

  assign clk_ena   = r_clk_ena;
  assign presc_cnt = r_div_cnt;

endmodule

// File: tb/tb_clk_ena_prescaler.sv
// Directed testbench for clk_ena_prescaler (DIV_W=4, CKS_W=2).
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_clk_ena_prescaler;

  logic       clk;
  logic       rst;
  logic       presc_en;
  logic [1:0] cks;
  logic       sync_clr;
  logic       clk_ena;
  logic [3:0] presc_cnt;

  int n_total;
  int n_bad;

  clk_ena_prescaler #(.DIV_W(4), .CKS_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .presc_en  (presc_en),
    .cks       (cks),
    .sync_clr  (sync_clr),
    .clk_ena   (clk_ena),
    .presc_cnt (presc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare both outputs against hand-derived values for one edge.
  task automatic cmp_outs(input string name, input int e, input logic exp_ena,
                          input logic [3:0] exp_cnt);
    n_total++;
    if (clk_ena !== exp_ena) begin
      n_bad++;
      $display("FAIL %s edge %0d clk_ena: got %b want %b", name, e, clk_ena, exp_ena);
    end
    n_total++;
    if (presc_cnt !== exp_cnt) begin
      n_bad++;
      $display("FAIL %s edge %0d presc_cnt: got %0d want %0d", name, e, presc_cnt, exp_cnt);
    end
  endtask

  // Reset holds outputs at zero across edges; release mid-cycle.
  task automatic test_reset();
    rst = 1'b1; presc_en = 1'b1; cks = 2'd0; sync_clr = 1'b0;
    tick();
    tick();
    cmp_outs("reset", 0, 1'b0, 4'd0);
    rst = 1'b0;
  endtask

  // T1: divide by 2 from reset release, pulses after even edges.
  task automatic test_div2();
    int pulses;
    pulses = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (clk_ena === 1'b1) pulses++;
      cmp_outs("div2", e, (e % 2) == 0, 4'(e % 16));
    end
    n_total++;
    if (pulses != 10) begin
      n_bad++;
      $display("FAIL div2_pulse_count: got %0d want 10", pulses);
    end
  endtask

  // T2: switch to k=3; pulse after E9 then every 16, no pulse at wrap.
  task automatic test_div16();
    cks = 2'd3;
    tick();
    cmp_outs("div16_restart", 0, 1'b0, 4'd0);
    for (int e = 1; e <= 40; e++) begin
      tick();
      cmp_outs("div16", e, (e >= 9) && (((e - 9) % 16) == 0), 4'(e % 16));
    end
  endtask

  // T3: running at k=0, change to k=2; pulse after E5 then every 8.
  task automatic test_cks_change();
    cks = 2'd0;
    tick();
    tick();
    tick();
    tick();
    cks = 2'd2;
    tick();
    cmp_outs("cks_chg_restart", 0, 1'b0, 4'd0);
    for (int e = 1; e <= 20; e++) begin
      tick();
      cmp_outs("cks_chg", e, (e >= 5) && (((e - 5) % 8) == 0), 4'(e % 16));
    end
  endtask

  // T4: k=1, pause for 7 edges with a tap rise pending; one pulse on resume.
  task automatic test_pause();
    cks = 2'd1;
    tick();
    cmp_outs("pause_restart", 0, 1'b0, 4'd0);
    tick();
    cmp_outs("pause_pre", 1, 1'b0, 4'd1);
    tick();
    cmp_outs("pause_pre", 2, 1'b0, 4'd2);
    presc_en = 1'b0;
    for (int e = 3; e <= 9; e++) begin
      tick();
      cmp_outs("pause_frozen", e, 1'b0, 4'd2);
    end
    presc_en = 1'b1;
    tick();
    cmp_outs("pause_resume", 10, 1'b1, 4'd3);
    for (int e = 11; e <= 14; e++) begin
      tick();
      cmp_outs("pause_after", e, e == 14, 4'(e - 7));
    end
  endtask

  // T5: asynchronous reset asserted between edges while a pulse is high.
  task automatic test_async_reset();
    cks = 2'd0;
    tick();
    tick();
    tick();
    cmp_outs("arst_pre", 2, 1'b1, 4'd2);
    #2;
    rst = 1'b1;
    #1;
    cmp_outs("arst_now", 0, 1'b0, 4'd0);
    #2;
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      cmp_outs("arst_after", e, (e % 2) == 0, 4'(e));
    end
  endtask

  // T6: sync_clr restart (also killing a due pulse), combined clear plus
  // select change, and a clear taken while paused.
  task automatic test_sync_clr();
    cks = 2'd1;
    tick();
    tick();
    tick();
    // Without the clear this edge would raise clk_ena.
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    cmp_outs("sclr_restart", 0, 1'b0, 4'd0);
    for (int e = 1; e <= 12; e++) begin
      tick();
      cmp_outs("sclr", e, (e >= 3) && (((e - 3) % 4) == 0), 4'(e));
    end
    sync_clr = 1'b1;
    cks = 2'd0;
    tick();
    sync_clr = 1'b0;
    cmp_outs("sclr_cks_restart", 0, 1'b0, 4'd0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      cmp_outs("sclr_cks", e, (e % 2) == 0, 4'(e));
    end
    presc_en = 1'b0;
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    cmp_outs("sclr_paused", 0, 1'b0, 4'd0);
    tick();
    cmp_outs("sclr_paused_hold", 1, 1'b0, 4'd0);
    presc_en = 1'b1;
    tick();
    cmp_outs("sclr_paused_resume", 1, 1'b0, 4'd1);
    tick();
    cmp_outs("sclr_paused_resume", 2, 1'b1, 4'd2);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    test_reset();
    test_div2();
    test_div16();
    test_cks_change();
    test_pause();
    test_async_reset();
    test_sync_clr();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
